// File: rtl/btn_arb_pkg.sv
// Shared definitions for the pushbutton arbiter: FSM state encoding and
// default sizing constants.
package btn_arb_pkg;

  localparam int DEF_NUM_BTN        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/button_arbiter_rr_picker.sv
// Combinational round-robin selector: scans the request vector starting at
// rr_ptr, wrapping from NUM_BTN-1 back to 0, and reports the first hit.
module rr_picker #(
  parameter int NUM_BTN = 4,
  parameter int IDW     = $clog2(NUM_BTN)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               any,
  output logic [IDW-1:0]     index
);

  // First requester at or after rr_ptr (modulo NUM_BTN) wins.
  always_comb begin
    logic found;
    int   k;
    found = 1'b0;
    k     = 0;
    index = '0;
    for (int j = 0; j < NUM_BTN; j++) begin
      k = int'(rr_ptr) + j;
      if (k >= NUM_BTN) k = k - NUM_BTN;
      if (!found && req[k]) begin
        found = 1'b1;
        index = k[IDW-1:0];
      end
    end
    any = found;
  end

endmodule

// File: rtl/button_arbiter.sv
// Pushbutton request arbiter. Queues one-cycle press pulses per button,
// grants them round-robin to the multiplier sequencer and waits for op_done.
//
// state | meaning
// IDLE  | nothing in flight; pick next pending button if any
// ISSUE | cmd_id registered; cmd_valid offered until cmd_ready
// WAIT  | command accepted; waiting for op_done (or timeout)
//
// Optional build macro BUTTON_ARBITER_TIMEOUT_EN: abandons WAIT after
// TIMEOUT_CYCLES cycles without op_done and pulses timeout.
module button_arbiter
  import btn_arb_pkg::*;
#(
  parameter int NUM_BTN        = DEF_NUM_BTN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_pulse,
  output logic                       cmd_valid,
  output logic [$clog2(NUM_BTN)-1:0] cmd_id,
  input  logic                       cmd_ready,
  input  logic                       op_done,
  output logic [NUM_BTN-1:0]         pending,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic                       timeout
);

  localparam int IDW = $clog2(NUM_BTN);

  logic [1:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic               pick_any;
  logic [IDW-1:0]     pick_idx;
  logic               accept;
  logic [NUM_BTN-1:0] acc_mask;
  logic [NUM_BTN-1:0] ovf_hit;

`ifdef BUTTON_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;
`endif

  rr_picker #(
    .NUM_BTN (NUM_BTN),
    .IDW     (IDW)
  ) u_picker (
    .req    (pending),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .index  (pick_idx)
  );

  assign accept  = (state == ST_ISSUE) && cmd_valid && cmd_ready;
  assign ovf_hit = btn_pulse & pending & ~acc_mask;

  // One-hot view of the button whose command is accepted this cycle.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      acc_mask[i] = accept && (cmd_id == IDW'(i));
    end
  end

  // Press queue and sticky overflow; a new press beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~acc_mask) | btn_pulse;
      overflow <= (|ovf_hit) | (overflow & ~ovf_clr);
    end
  end

  // Grant sequencing. cmd_id is registered on leaving IDLE and cmd_valid
  // rises one cycle later, so the index is settled before it is offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      rr_ptr    <= '0;
`ifdef BUTTON_ARBITER_TIMEOUT_EN
      tmo_cnt   <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef BUTTON_ARBITER_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            cmd_id <= pick_idx;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            cmd_valid <= 1'b0;
            state     <= ST_WAIT;
            rr_ptr    <= (cmd_id == IDW'(NUM_BTN - 1)) ? '0 : cmd_id + 1'b1;
`ifdef BUTTON_ARBITER_TIMEOUT_EN
            tmo_cnt   <= CW'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            cmd_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (op_done) begin
            state <= ST_IDLE;
          end
`ifdef BUTTON_ARBITER_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef BUTTON_ARBITER_TIMEOUT_EN
  // No timeout logic in this build; the parameter stays so both builds
  // share one instance signature.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule
